// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-size codes and lane widths.
package pacote_acesso_memoria;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    LER      = 2'b01,
    ESCREVER = 2'b10,
    RESPOSTA = 2'b11
  } estado_t;

  localparam logic [1:0] TAM_BYTE    = 2'b00;
  localparam logic [1:0] TAM_MEIA    = 2'b01;
  localparam logic [1:0] TAM_PALAVRA = 2'b10;
  localparam logic [1:0] TAM_ILEGAL  = 2'b11;

  localparam int unsigned LARGURA_BYTE    = 8;
  localparam int unsigned LARGURA_MEIA    = 16;
  localparam int unsigned LARGURA_PALAVRA = 32;

endpackage

// File: rtl/unidade_acesso_memoria_alinhador_bytes.sv
// Little-endian lane extract/extend for loads and lane merge for read-modify-write stores.
module alinhador_bytes
  import pacote_acesso_memoria::*;
(
  input  logic [LARGURA_PALAVRA-1:0] palavra,
  input  logic [LARGURA_PALAVRA-1:0] dado,
  input  logic [1:0]                 faixa,
  input  logic [1:0]                 tamanho,
  input  logic                       sinal,
  output logic [LARGURA_PALAVRA-1:0] extraido_c,
  output logic [LARGURA_PALAVRA-1:0] mesclado_c
);

  localparam int unsigned EXT_BYTE = LARGURA_PALAVRA - LARGURA_BYTE;
  localparam int unsigned EXT_MEIA = LARGURA_PALAVRA - LARGURA_MEIA;

  logic [4:0]                 desl_byte;
  logic [4:0]                 desl_meia;
  logic [LARGURA_PALAVRA-1:0] deslocada;

  always_comb begin
    desl_byte  = {faixa, 3'b000};
    desl_meia  = {faixa[1], 4'b0000};
    deslocada  = '0;
    extraido_c = palavra;
    mesclado_c = dado;
    case (tamanho)
      TAM_BYTE: begin
        deslocada  = palavra >> desl_byte;
        extraido_c = {{EXT_BYTE{sinal & deslocada[LARGURA_BYTE-1]}}, deslocada[LARGURA_BYTE-1:0]};
        mesclado_c = (palavra & ~(32'h0000_00FF << desl_byte))
                   | ({{EXT_BYTE{1'b0}}, dado[LARGURA_BYTE-1:0]} << desl_byte);
      end
      TAM_MEIA: begin
        deslocada  = palavra >> desl_meia;
        extraido_c = {{EXT_MEIA{sinal & deslocada[LARGURA_MEIA-1]}}, deslocada[LARGURA_MEIA-1:0]};
        mesclado_c = (palavra & ~(32'h0000_FFFF << desl_meia))
                   | ({{EXT_MEIA{1'b0}}, dado[LARGURA_MEIA-1:0]} << desl_meia);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Load/store unit in front of a word-addressed data memory; one request in flight at a time.
// Byte/halfword support is built only when UNIDADE_ACESSO_MEMORIA_SUBWORD_EN is defined.
module unidade_acesso_memoria
  import pacote_acesso_memoria::*;
#(
  parameter int unsigned PROFUNDIDADE = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReqValido,
  output logic        Pronto,
  input  logic        ReqEscrita,
  input  logic [1:0]  ReqTamanho,
  input  logic        ReqSinal,
  input  logic [31:0] ReqEndereco,
  input  logic [31:0] ReqDado,
  output logic        RespValido,
  output logic [31:0] RespDado,
  output logic        RespErro,
  output logic [31:0] MemEndereco,
  output logic [31:0] MemDadoEscrita,
  output logic        MemFlagEscrita,
  input  logic [31:0] MemDadoLeitura
);

  localparam int unsigned W = LARGURA_PALAVRA;

  estado_t       estado_q, estado_d;
  logic [W-1:0]  mem_endereco_q, mem_endereco_d;
  logic [W-1:0]  mem_dado_escrita_q, mem_dado_escrita_d;
  logic [W-1:0]  resp_dado_q, resp_dado_d;
  logic          resp_erro_q, resp_erro_d;
  logic          escrita_q, escrita_d;
  logic [1:0]    tamanho_q, tamanho_d;
  logic          sinal_q, sinal_d;
  logic [1:0]    faixa_q, faixa_d;
  logic [W-1:0]  dado_q, dado_d;
  logic          erro_c;
  logic          subpalavra_c;
  logic [W-1:0]  extraido_c;
  logic [W-1:0]  mesclado_c;

  // Request validation, evaluated on the incoming fields at the accept edge
  always_comb begin
    erro_c = ({2'b00, ReqEndereco[31:2]} >= PROFUNDIDADE);
`ifdef UNIDADE_ACESSO_MEMORIA_SUBWORD_EN
    erro_c = erro_c
           || (ReqTamanho == TAM_ILEGAL)
           || ((ReqTamanho == TAM_MEIA) && ReqEndereco[0])
           || ((ReqTamanho == TAM_PALAVRA) && (ReqEndereco[1:0] != 2'b00));
    subpalavra_c = (ReqTamanho != TAM_PALAVRA);
`else
    erro_c = erro_c
           || (ReqTamanho != TAM_PALAVRA)
           || (ReqEndereco[1:0] != 2'b00);
    subpalavra_c = 1'b0;
`endif
  end

  alinhador_bytes u_alinhador (
    .palavra    (MemDadoLeitura),
    .dado       (dado_q),
    .faixa      (faixa_q),
    .tamanho    (tamanho_q),
    .sinal      (sinal_q),
    .extraido_c (extraido_c),
    .mesclado_c (mesclado_c)
  );

`ifndef UNIDADE_ACESSO_MEMORIA_SUBWORD_EN
  logic unused_sem_subpalavra;
  assign unused_sem_subpalavra = ^{mesclado_c, escrita_q};
`endif

  always_comb begin
    estado_d           = estado_q;
    mem_endereco_d     = mem_endereco_q;
    mem_dado_escrita_d = mem_dado_escrita_q;
    resp_dado_d        = '0;
    resp_erro_d        = 1'b0;
    escrita_d          = escrita_q;
    tamanho_d          = tamanho_q;
    sinal_d            = sinal_q;
    faixa_d            = faixa_q;
    dado_d             = dado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (ReqValido) begin
          mem_endereco_d = {2'b00, ReqEndereco[31:2]};
          escrita_d      = ReqEscrita;
          tamanho_d      = ReqTamanho;
          sinal_d        = ReqSinal;
          faixa_d        = ReqEndereco[1:0];
          dado_d         = ReqDado;
          if (erro_c) begin
            estado_d    = RESPOSTA;
            resp_erro_d = 1'b1;
          end else if (!ReqEscrita || subpalavra_c) begin
            estado_d = LER;
          end else begin
            estado_d           = ESCREVER;
            mem_dado_escrita_d = ReqDado;
          end
        end
      end
      LER: begin
`ifdef UNIDADE_ACESSO_MEMORIA_SUBWORD_EN
        if (escrita_q) begin
          estado_d           = ESCREVER;
          mem_dado_escrita_d = mesclado_c;
        end else begin
          estado_d    = RESPOSTA;
          resp_dado_d = extraido_c;
        end
`else
        estado_d    = RESPOSTA;
        resp_dado_d = extraido_c;
`endif
      end
      ESCREVER: estado_d = RESPOSTA;
      RESPOSTA: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q           <= OCIOSO;
      mem_endereco_q     <= '0;
      mem_dado_escrita_q <= '0;
      resp_dado_q        <= '0;
      resp_erro_q        <= 1'b0;
      escrita_q          <= 1'b0;
      tamanho_q          <= 2'b00;
      sinal_q            <= 1'b0;
      faixa_q            <= 2'b00;
      dado_q             <= '0;
    end else begin
      estado_q           <= estado_d;
      mem_endereco_q     <= mem_endereco_d;
      mem_dado_escrita_q <= mem_dado_escrita_d;
      resp_dado_q        <= resp_dado_d;
      resp_erro_q        <= resp_erro_d;
      escrita_q          <= escrita_d;
      tamanho_q          <= tamanho_d;
      sinal_q            <= sinal_d;
      faixa_q            <= faixa_d;
      dado_q             <= dado_d;
    end
  end

  assign Pronto         = (estado_q == OCIOSO);
  assign RespValido     = (estado_q == RESPOSTA);
  assign MemFlagEscrita = (estado_q == ESCREVER);
  assign MemEndereco    = mem_endereco_q;
  assign MemDadoEscrita = mem_dado_escrita_q;
  assign RespDado       = resp_dado_q;
  assign RespErro       = resp_erro_q;

endmodule

// File: doc/unidade_acesso_memoria.md
UNIDADE_ACESSO_MEMORIA -- requirements
Module: unidade_acesso_memoria

Interface
REQ-001 Parameter PROFUNDIDADE, default 20, SHALL set the data-memory depth in 32-bit words.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ReqValido  in  1  request present.
REQ-005 Pronto  out  1  unit can accept; SHALL equal (state == OCIOSO).
REQ-006 ReqEscrita  in  1  1 = store, 0 = load.
REQ-007 ReqTamanho  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 ReqSinal  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-009 ReqEndereco  in  32  byte address.
REQ-010 ReqDado  in  32  store data, right-aligned.
REQ-011 RespValido  out  1  one-cycle completion pulse.
REQ-012 RespDado  out  32  load result; 0 for stores and errors.
REQ-013 RespErro  out  1  qualified by RespValido.
REQ-014 MemEndereco  out  32  word index to data memory: {2'b00, ReqEndereco[31:2]}.
REQ-015 MemDadoEscrita  out  32  write data to data memory.
REQ-016 MemFlagEscrita  out  1  write enable to data memory.
REQ-017 MemDadoLeitura  in  32  read data; the memory updates it on the falling edge, so it is valid at the next rising edge.

Function
REQ-018 States SHALL be OCIOSO, LER, ESCREVER and RESPOSTA.
REQ-019 A request SHALL be accepted on a rising edge with ReqValido=1 in OCIOSO; all request fields SHALL be latched at that edge.
REQ-020 An error SHALL occur if the word index is >= PROFUNDIDADE, ReqTamanho=11, the halfword has addr[0]=1, or the word has addr[1:0]!=0; the unit then goes OCIOSO->RESPOSTA with RespErro=1 and no memory access.
REQ-021 Load: OCIOSO->LER->RESPOSTA; MemDadoLeitura SHALL be captured at the LER->RESPOSTA edge.
REQ-022 Word store: OCIOSO->ESCREVER->RESPOSTA.
REQ-023 Sub-word store: OCIOSO->LER->ESCREVER->RESPOSTA, writing the read word with only the addressed lanes replaced (read-modify-write).
REQ-024 Byte lanes SHALL be little-endian: lane = addr[1:0]; a halfword occupies lanes {addr[1],0} and {addr[1],1}.
REQ-025 A sub-word load SHALL extract the addressed lanes and extend them per ReqSinal.
REQ-026 MemFlagEscrita SHALL be 1 only in ESCREVER; MemEndereco SHALL hold the latched index in LER and ESCREVER.
REQ-027 RESPOSTA SHALL last exactly one cycle with RespValido=1, then go to OCIOSO; RespValido SHALL be 0 in every other state.
REQ-028 ReqValido outside OCIOSO SHALL be ignored; there is no response backpressure.
REQ-029 Latency from the accept edge to RespValido SHALL be 1 cycle for errors, 2 for loads and word stores, and 3 for sub-word stores.

Reset
REQ-030 While reset=1: state OCIOSO, RespValido=0, RespErro=0, RespDado=0, MemFlagEscrita=0, MemEndereco=0, MemDadoEscrita=0, latches cleared, requests ignored.
REQ-031 Reset during any state SHALL abort the operation immediately; there SHALL be no response and no later write.

Configuration
REQ-032 Macro UNIDADE_ACESSO_MEMORIA_SUBWORD_EN SHALL gate byte/halfword support.
REQ-033 Without the macro, ReqTamanho != 10 SHALL produce an error response, ReqSinal SHALL be ignored, and the LER->ESCREVER path SHALL be absent.

Structure
REQ-034 Package pacote_acesso_memoria SHALL hold the state enum, the ReqTamanho codes and the lane-width constants.
REQ-035 Combinational sub-module alinhador_bytes SHALL perform lane extract/extend and lane merge.

Verification
REQ-036 Word store at 0x08 with data 0xDEADBEEF -> MemFlagEscrita=1 for one cycle with MemEndereco=2, then RespValido; a load from 0x08 -> RespDado=0xDEADBEEF two cycles after accept.
REQ-037 Word 0x11223344 at 0x0C; byte store 0xAA at 0x0E -> LER then ESCREVER with MemDadoEscrita=0x11AA3344; RespValido three cycles after accept.
REQ-038 Word 0x0000F080 at 0x10; signed byte load from 0x10 -> 0xFFFFFF80; unsigned halfword load from 0x10 -> 0x0000F080; signed halfword load from 0x10 -> 0xFFFFF080.
REQ-039 Load from 0x50 (index 20) and halfword load from 0x03 -> RespErro=1 one cycle after accept, with no MemFlagEscrita pulse and RespDado=0.
REQ-040 Reset asserted during ESCREVER before the falling edge -> the memory word is unchanged, there is no RespValido, and Pronto=1 after reset releases.
REQ-041 Back-to-back requests with ReqValido held high -> only one is accepted per transaction, and the next is accepted on the edge after RESPOSTA.
